x2c_ctrl_fifo_rd: RTL and testbench

Read-side consumer of the 1024x32 x2c control FIFO. Pops two-word control descriptors (header, address) from the FIFO read port and presents each one to the LMAC core as a single parallel descriptor with a valid/ready handshake. Header fields are validated on the way through. Sits between the FIFO read port and the core's transmit/receive control logic, in the FIFO read-clock domain.

---
 rtl/x2c_ctrl_pkg.sv | 30 +++
 rtl/x2c_ctrl_hdr_chk.sv | 20 ++
 rtl/x2c_ctrl_fifo_rd.sv | 105 ++++++++++
 tb/tb_x2c_ctrl_fifo_rd.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x2c_ctrl_pkg.sv
// Shared definitions for the x2c control FIFO: FSM states, command codes,
// header field layout and the default maximum byte length.
package x2c_ctrl_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned TAG_W   = 12;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned CMD_LSB = 28;
  localparam int unsigned TAG_LSB = 16;
  localparam int unsigned LEN_LSB = 0;

  localparam logic [CMD_W-1:0] CMD_RX      = 4'h1;
  localparam logic [CMD_W-1:0] CMD_TX      = 4'h2;
  localparam logic [LEN_W-1:0] MAX_LEN_DEF = 16'd9600;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    POP_H = 5'b00010,
    POP_A = 5'b00100,
    CAP_A = 5'b01000,
    HOLD  = 5'b10000
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [TAG_W-1:0] tag;
    logic [LEN_W-1:0] len;
  } hdr_t;

endpackage

// File: rtl/x2c_ctrl_hdr_chk.sv
// Combinational header validator shared by the read and write sides of the
// x2c control FIFO: flags unknown commands and zero or oversize lengths.
module x2c_ctrl_hdr_chk
  import x2c_ctrl_pkg::*;
#(
  parameter logic [LEN_W-1:0] MAX_LEN = MAX_LEN_DEF
) (
  input  logic [CMD_W-1:0] cmd,
  input  logic [LEN_W-1:0] len,
  output logic             err_c
);

  always_comb begin
    err_c = 1'b0;
    if ((cmd != CMD_RX) && (cmd != CMD_TX)) err_c = 1'b1;
    if (len == '0)                          err_c = 1'b1;
    if (len > MAX_LEN)                      err_c = 1'b1;
  end

endmodule

// File: rtl/x2c_ctrl_fifo_rd.sv
// Read side of the x2c control FIFO: pops header+address pairs and presents
// them as one validated descriptor. Optional counters under X2C_CTRL_STATS_EN.
module x2c_ctrl_fifo_rd
  import x2c_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      PTR     = 10,
  parameter logic [LEN_W-1:0] MAX_LEN = MAX_LEN_DEF
) (
  input  logic             rdclk,
  input  logic             aclr,
  output logic             rdreq,
  input  logic [WIDTH-1:0] q,
  input  logic             empty,
  input  logic [PTR:0]     usedw,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic [3:0]       ctrl_cmd,
  output logic [11:0]      ctrl_tag,
  output logic [15:0]      ctrl_len,
  output logic [31:0]      ctrl_addr,
  output logic             ctrl_err
`ifdef X2C_CTRL_STATS_EN
  ,
  output logic [31:0]      desc_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [PTR:0] USEDW_MIN = (PTR+1)'(2);

  state_e state, state_nxt;
  hdr_t   hdr_q;
  logic   hdr_err_c;

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Only start a descriptor once both of its words are in the FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty && (usedw >= USEDW_MIN)) state_nxt = POP_H;
      POP_H:   state_nxt = POP_A;
      POP_A:   state_nxt = CAP_A;
      CAP_A:   state_nxt = HOLD;
      HOLD:    if (ctrl_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rdreq = (state == POP_H) || (state == POP_A);

  x2c_ctrl_hdr_chk #(
    .MAX_LEN (MAX_LEN)
  ) u_hdr_chk (
    .cmd   (hdr_q.cmd),
    .len   (hdr_q.len),
    .err_c (hdr_err_c)
  );

  // q is non-showahead: header is on q during POP_A, address during CAP_A.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      hdr_q      <= '0;
      ctrl_addr  <= '0;
      ctrl_err   <= 1'b0;
      ctrl_valid <= 1'b0;
    end else begin
      if (state == POP_A) begin
        hdr_q <= '{cmd: q[CMD_LSB +: CMD_W],
                   tag: q[TAG_LSB +: TAG_W],
                   len: q[LEN_LSB +: LEN_W]};
      end
      if (state == CAP_A) begin
        ctrl_addr <= 32'(q);
        ctrl_err  <= hdr_err_c;
      end
      ctrl_valid <= (state_nxt == HOLD);
    end
  end

  assign ctrl_cmd = hdr_q.cmd;
  assign ctrl_tag = hdr_q.tag;
  assign ctrl_len = hdr_q.len;

`ifdef X2C_CTRL_STATS_EN
  logic hs;
  assign hs = ctrl_valid & ctrl_ready;

  // Saturating handshake and error counters.
  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      desc_cnt <= '0;
      err_cnt  <= '0;
    end else if (hs) begin
      if (desc_cnt != '1)             desc_cnt <= desc_cnt + 32'd1;
      if (ctrl_err && (err_cnt != '1)) err_cnt  <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_x2c_ctrl_fifo_rd.sv
// Self-checking bench for x2c_ctrl_fifo_rd with a behavioural FIFO and a
// descriptor-level reference model; counter checks under X2C_CTRL_STATS_EN.
module tb_x2c_ctrl_fifo_rd;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        rdreq;
  logic [31:0] q = 32'h0;
  logic        empty = 1'b1;
  logic [10:0] usedw = 11'd0;
  logic        ctrl_valid;
  logic        ctrl_ready = 1'b0;
  logic [3:0]  ctrl_cmd;
  logic [11:0] ctrl_tag;
  logic [15:0] ctrl_len;
  logic [31:0] ctrl_addr;
  logic        ctrl_err;
`ifdef X2C_CTRL_STATS_EN
  logic [31:0] desc_cnt;
  logic [15:0] err_cnt;
`endif

  x2c_ctrl_fifo_rd dut (
    .rdclk      (clk),
    .aclr       (aclr),
    .rdreq      (rdreq),
    .q          (q),
    .empty      (empty),
    .usedw      (usedw),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_cmd   (ctrl_cmd),
    .ctrl_tag   (ctrl_tag),
    .ctrl_len   (ctrl_len),
    .ctrl_addr  (ctrl_addr),
    .ctrl_err   (ctrl_err)
`ifdef X2C_CTRL_STATS_EN
    ,
    .desc_cnt   (desc_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] tag;
    logic [15:0] len;
    logic [31:0] addr;
    logic        err;
  } desc_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        fifo_clr = 1'b0;
  logic [31:0] fifo[$];
  logic [31:0] pend[$];
  logic [31:0] mw[$];
  desc_t       exp_q[$];
  int          rd_cycles[$];
  int          val_cycles[$];
  logic        del_err[$];
  desc_t       last_d;

  // Behavioural non-showahead FIFO; the bench writes at most one word per clock.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      fifo.delete();
      pend.delete();
    end else begin
      if (rdreq && (fifo.size() > 0)) q <= fifo.pop_front();
      if (pend.size() > 0) fifo.push_back(pend.pop_front());
    end
    usedw <= 11'(fifo.size());
    empty <= (fifo.size() == 0);
  end

  function automatic logic [64:0] pk(input desc_t d);
    return {d.cmd, d.tag, d.len, d.addr, d.err};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: every two pushed words form one expected descriptor.
  task automatic push_word(input logic [31:0] w);
    desc_t       d;
    logic [31:0] h;
    pend.push_back(w);
    mw.push_back(w);
    if (mw.size() == 2) begin
      h      = mw[0];
      d.cmd  = 4'(h >> 28);
      d.tag  = 12'(h >> 16);
      d.len  = 16'(h);
      d.addr = mw[1];
      d.err  = !((d.cmd == 4'd1) || (d.cmd == 4'd2)) || (d.len == 16'd0) || (d.len > 16'd9600);
      exp_q.push_back(d);
      mw.delete();
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  task automatic check_cycle();
    desc_t e;
    if (aclr) begin
      check("reset_outputs",
            128'({rdreq, ctrl_valid, ctrl_err, ctrl_cmd, ctrl_tag, ctrl_len, ctrl_addr}), 128'(0));
`ifdef X2C_CTRL_STATS_EN
      check("reset_counters", 128'({desc_cnt, err_cnt}), 128'(0));
`endif
    end else begin
      if (rdreq) rd_cycles.push_back(cyc);
      if (ctrl_valid) begin
        check("no_pop_in_hold", 128'(rdreq), 128'(0));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_desc: got %0h, expected no descriptor",
                   {ctrl_cmd, ctrl_tag, ctrl_len, ctrl_addr, ctrl_err});
        end else begin
          e = exp_q[0];
          check("desc", 128'({ctrl_cmd, ctrl_tag, ctrl_len, ctrl_addr, ctrl_err}), 128'(pk(e)));
          if (ctrl_ready) begin
            last_d.cmd  = ctrl_cmd;
            last_d.tag  = ctrl_tag;
            last_d.len  = ctrl_len;
            last_d.addr = ctrl_addr;
            last_d.err  = ctrl_err;
            del_err.push_back(ctrl_err);
            val_cycles.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aclr     = 1'b1;
    fifo_clr = 1'b1;
    mw.delete();
    exp_q.delete();
    tick();
    fifo_clr = 1'b0;
    tick();
    aclr = 1'b0;
  endtask

  initial begin
    int r, n0, h0, u, d;
    #1 aclr = 1'b1;
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;

    // Reset with two words preloaded, then a single descriptor.
    ctrl_ready = 1'b1;
    push_word(32'h1ABC_0040);
    push_word(32'h8000_1000);
    repeat (4) tick();
    check("preload_usedw", 128'(usedw), 128'(2));
    aclr = 1'b0;
    r = cyc;
    repeat (8) tick();
    check("single_rdreq_count", 128'(rd_cycles.size()), 128'(2));
    if (rd_cycles.size() >= 2) begin
      check("first_rdreq_cycle", 128'(rd_cycles[0] - r), 128'(1));
      check("second_rdreq_cycle", 128'(rd_cycles[1] - r), 128'(2));
    end
    check("single_valid_count", 128'(val_cycles.size()), 128'(1));
    if (val_cycles.size() >= 1) check("single_latency", 128'(val_cycles[0] - r), 128'(4));
    check("single_desc_literal", 128'(pk(last_d)),
          128'({4'h1, 12'hABC, 16'd64, 32'h8000_1000, 1'b0}));

    // Partial arrival: one word must not start a descriptor.
    n0 = rd_cycles.size();
    push_word(32'h1000_0100);
    repeat (20) tick();
    check("partial_no_pop", 128'(rd_cycles.size() - n0), 128'(0));
    check("partial_usedw", 128'(usedw), 128'(1));
    push_word(32'h0000_2000);
    u = -1;
    for (int i = 0; i < 10 && u < 0; i++) begin
      tick();
      if (usedw == 11'd2) u = cyc;
    end
    repeat (3) tick();
    d = (rd_cycles.size() > n0 && u >= 0) ? rd_cycles[n0] - u : -1;
    check("partial_start_within_2", 128'((d >= 1) && (d <= 2)), 128'(1));
    repeat (6) tick();
    check("partial_desc_literal", 128'(pk(last_d)),
          128'({4'h1, 12'h000, 16'd256, 32'h0000_2000, 1'b0}));

    // Backpressure: three descriptors queued behind a stalled consumer.
    ctrl_ready = 1'b0;
    n0 = rd_cycles.size();
    h0 = val_cycles.size();
    push_word(32'h2000_0200); push_word(32'hA000_0001);
    push_word(32'h1123_0001); push_word(32'hB000_0002);
    push_word(32'h2FFF_2580); push_word(32'hC000_0003);
    repeat (50) tick();
    check("bp_pops", 128'(rd_cycles.size() - n0), 128'(2));
    check("bp_usedw", 128'(usedw), 128'(4));
    check("bp_valid_held", 128'(ctrl_valid), 128'(1));
    check("bp_held_desc_literal", 128'({ctrl_cmd, ctrl_tag, ctrl_len, ctrl_addr}),
          128'({4'h2, 12'h000, 16'd512, 32'hA000_0001}));
    ctrl_ready = 1'b1;
    repeat (20) tick();
    check("bp_delivered", 128'(val_cycles.size() - h0), 128'(3));
    if (val_cycles.size() - h0 == 3) begin
      check("bp_gap_1", 128'(val_cycles[h0+1] - val_cycles[h0]), 128'(5));
      check("bp_gap_2", 128'(val_cycles[h0+2] - val_cycles[h0+1]), 128'(5));
    end
    check("bp_last_literal", 128'(pk(last_d)),
          128'({4'h2, 12'hFFF, 16'd9600, 32'hC000_0003, 1'b0}));

    // Validation rules and the MAX_LEN boundary.
    n0 = del_err.size();
    push_word(32'h3000_0040); push_word(32'hD000_0001);
    push_word(32'h2000_0000); push_word(32'hD000_0002);
    push_word(32'h2000_2581); push_word(32'hD000_0003);
    push_word(32'h2000_2580); push_word(32'hD000_0004);
    repeat (32) tick();
    check("err_delivered", 128'(del_err.size() - n0), 128'(4));
    if (del_err.size() - n0 == 4) begin
      check("err_bad_cmd", 128'(del_err[n0]), 128'(1));
      check("err_len_zero", 128'(del_err[n0+1]), 128'(1));
      check("err_len_9601", 128'(del_err[n0+2]), 128'(1));
      check("err_len_9600_ok", 128'(del_err[n0+3]), 128'(0));
    end
    check("all_consumed", 128'(exp_q.size()), 128'(0));

    // Reset mid-descriptor drops the partial descriptor.
    h0 = val_cycles.size();
    push_word(32'h1555_0010); push_word(32'hE000_0001);
    repeat (4) tick();
    do_reset();
    repeat (10) tick();
    check("midreset_dropped", 128'(val_cycles.size() - h0), 128'(0));
    push_word(32'h2777_0020); push_word(32'hE000_0002);
    repeat (10) tick();
    check("after_reset_desc", 128'(pk(last_d)),
          128'({4'h2, 12'h777, 16'd32, 32'hE000_0002, 1'b0}));

`ifdef X2C_CTRL_STATS_EN
    do_reset();
    push_word(32'h1001_0040); push_word(32'hF000_0001);
    push_word(32'h0002_0040); push_word(32'hF000_0002);
    push_word(32'h2003_0100); push_word(32'hF000_0003);
    push_word(32'h1004_2580); push_word(32'hF000_0004);
    repeat (35) tick();
    check("stats_desc_cnt", 128'(desc_cnt), 128'(4));
    check("stats_err_cnt", 128'(err_cnt), 128'(1));
    do_reset();
    tick();
    check("stats_cleared", 128'({desc_cnt, err_cnt}), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
